// File: rtl/irq_pkg.sv
// Shared state type, default source count and priority encoder for the
// external interrupt controller.
`timescale 1ns/1ps
package irq_pkg;

   localparam int NSRC_DEFAULT = 8;
   localparam int MAXSRC       = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_EOI = 2'd2
   } irq_state_t;

   // Lowest set index wins; callers narrow the result to their id width.
   function automatic logic [4:0] prio_enc(input logic [MAXSRC-1:0] v);
      logic [4:0] id;
      id = '0;
      for (int i = MAXSRC - 1; i >= 0; i--) begin
         if (v[i]) id = 5'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source two-flop synchronizer followed by a rising-edge detector.
`timescale 1ns/1ps
module irq_sync_edge
   import irq_pkg::*;
#(
   parameter int NSRC = NSRC_DEFAULT
)
(
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic [NSRC-1:0] d,
   output logic [NSRC-1:0] edge_o
);

   logic [NSRC-1:0] s1_q;
   logic [NSRC-1:0] s2_q;
   logic [NSRC-1:0] p_q;
   logic [NSRC-1:0] p_d;
   logic [1:0]      warm_q;

   // Until the chain has filled after reset, p follows s1 so that a line held
   // high through reset release lands in s2 and p together and never looks new.
   assign p_d    = warm_q[1] ? s2_q : s1_q;
   assign edge_o = s2_q & ~p_q;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         p_q    <= '0;
         warm_q <= '0;
      end else begin
         s1_q   <= d;
         s2_q   <= s1_q;
         p_q    <= p_d;
         warm_q <= {warm_q[0], 1'b1};
      end
   end

endmodule

// File: rtl/ext_irq_controller.sv
// Edge-latched, maskable, fixed-priority interrupt source for processor_arm
// with an ExtIRQ/ExtIAck handshake and end-of-interrupt blocking.
`timescale 1ns/1ps
module ext_irq_controller
   import irq_pkg::*;
#(
   parameter int NSRC = NSRC_DEFAULT,
   parameter int IDW  = $clog2(NSRC)
)
(
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wdata,
   output logic            ExtIRQ,
   input  logic            ExtIAck,
   input  logic            eoi,
   output logic [IDW-1:0]  irq_id,
   output logic [NSRC-1:0] irq_pending,
   output logic [NSRC-1:0] irq_mask
);

   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   cand;
   logic [MAXSRC-1:0] cand_w;
   logic [NSRC-1:0]   clr;
   logic [NSRC-1:0]   pend_q, pend_d;
   logic [NSRC-1:0]   mask_q, mask_d;
   logic [IDW-1:0]    id_q, id_d;
   logic              irq_q, irq_d;
   irq_state_t        state_q, state_d;

   irq_sync_edge #(.NSRC(NSRC)) u_sync (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .d        (irq_src),
      .edge_o   (rise)
   );

   assign cand   = pend_q & mask_q;
   assign mask_d = mask_we ? mask_wdata : mask_q;

   always_comb begin
      cand_w             = '0;
      cand_w[NSRC-1:0]   = cand;
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (|cand) begin
               state_d = REQ;
               id_d    = IDW'(prio_enc(cand_w));
            end
         end
         REQ: begin
            // An eoi in the same cycle as the ack is deliberately ignored.
            if (ExtIAck) begin
               state_d   = WAIT_EOI;
               clr[id_q] = 1'b1;
            end
         end
         WAIT_EOI: begin
            if (eoi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A new edge on the bit being acknowledged survives the clear.
      pend_d = (pend_q & ~clr) | rise;
      irq_d  = (state_d == REQ);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         pend_q  <= '0;
         mask_q  <= '1;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         irq_q   <= irq_d;
      end
   end

   assign ExtIRQ      = irq_q;
   assign irq_id      = id_q;
   assign irq_pending = pend_q;
   assign irq_mask    = mask_q;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Bench for ext_irq_controller: expected grant ids are queued when stimulus is
// issued and popped by an independent monitor on each ExtIRQ rise.
`timescale 1ns/1ps
module tb_ext_irq_controller;

   localparam int NSRC = 8;
   localparam int IDW  = 3;

   logic            CLOCK_50 = 1'b0;
   logic            reset;
   logic [NSRC-1:0] irq_src;
   logic            mask_we;
   logic [NSRC-1:0] mask_wdata;
   logic            ExtIRQ;
   logic            ExtIAck;
   logic            eoi;
   logic [IDW-1:0]  irq_id;
   logic [NSRC-1:0] irq_pending;
   logic [NSRC-1:0] irq_mask;

   int              n_checks = 0;
   int              n_errors = 0;
   int              exp_q[$];
   logic            irq_prev = 1'b0;
   logic [IDW-1:0]  held_id = '0;

   logic [7:0]      model_pend;
   logic [7:0]      rs;
   logic [7:0]      rm;
   int              rid;
   logic            in_wait;
   int              per_grants;

   ext_irq_controller #(.NSRC(NSRC)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .irq_src     (irq_src),
      .mask_we     (mask_we),
      .mask_wdata  (mask_wdata),
      .ExtIRQ      (ExtIRQ),
      .ExtIAck     (ExtIAck),
      .eoi         (eoi),
      .irq_id      (irq_id),
      .irq_pending (irq_pending),
      .irq_mask    (irq_mask)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h at %0t", name, act, $time);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int b = 0; b < 8; b++) begin
         if (v[b]) return b;
      end
      return -1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic do_ack();
      ExtIAck = 1'b1; cyc(1); ExtIAck = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1; cyc(1); eoi = 1'b0;
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_wdata = m; mask_we = 1'b1; cyc(1); mask_we = 1'b0;
   endtask

   task automatic wait_irq(input int budget);
      int n;
      n = 0;
      while (!ExtIRQ && n < budget) begin
         cyc(1);
         n++;
      end
      check("wait_irq", int'(ExtIRQ), 1);
   endtask

   // Grant monitor: one queued id per ExtIRQ rise, id frozen while requesting.
   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (ExtIRQ && !irq_prev) begin
            if (exp_q.size() == 0) check("grant_unexpected", int'(irq_id), -1);
            else check("grant_id", int'(irq_id), exp_q.pop_front());
            held_id = irq_id;
         end else if (ExtIRQ) begin
            check("id_frozen", int'(irq_id), int'(held_id));
         end
      end
      irq_prev = ExtIRQ;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
      ExtIAck = 1'b0; eoi = 1'b0;
      cyc(3);
      check("rst_irq",  int'(ExtIRQ), 0);
      check("rst_id",   int'(irq_id), 0);
      check("rst_pend", int'(irq_pending), 0);
      check("rst_mask", int'(irq_mask), 8'hFF);
      reset = 1'b0;
      cyc(3);

      // Single source: edge k, pending after k+2, request after k+3.
      irq_src = 8'h08; exp_q.push_back(3);
      cyc(2);
      check("t1_pend_k1", int'(irq_pending), 0);
      cyc(1);
      check("t1_pend_k2", int'(irq_pending), 8'h08);
      check("t1_irq_k2",  int'(ExtIRQ), 0);
      cyc(1);
      check("t1_irq_k3",  int'(ExtIRQ), 1);
      check("t1_id",      int'(irq_id), 3);
      cyc(10);
      check("t1_hold",    int'(ExtIRQ), 1);
      do_ack();
      check("t1_ack_irq",  int'(ExtIRQ), 0);
      check("t1_ack_pend", int'(irq_pending), 0);
      irq_src = '0;
      cyc(3);
      check("t1_wait_irq", int'(ExtIRQ), 0);
      do_eoi();
      cyc(2);

      // Priority: 1 before 5, with an idle gap between grants.
      irq_src = 8'h22; exp_q.push_back(1); exp_q.push_back(5);
      wait_irq(10);
      check("t2_first_id", int'(irq_id), 1);
      do_ack();
      check("t2_ack_pend", int'(irq_pending), 8'h20);
      cyc(4);
      check("t2_blocked",  int'(ExtIRQ), 0);
      do_eoi();
      check("t2_gap",      int'(ExtIRQ), 0);
      cyc(1);
      check("t2_second",   int'(ExtIRQ), 1);
      check("t2_second_id", int'(irq_id), 5);
      do_ack(); do_eoi();
      irq_src = '0;
      cyc(2);

      // Mask holds a pending source back; spurious handshakes are ignored.
      write_mask(8'hFB);
      check("t3_mask_rd", int'(irq_mask), 8'hFB);
      irq_src = 8'h04; cyc(1); irq_src = '0; cyc(4);
      check("t3_pend",   int'(irq_pending), 8'h04);
      check("t3_masked", int'(ExtIRQ), 0);
      do_ack();
      check("t3_spur_ack_pend", int'(irq_pending), 8'h04);
      check("t3_spur_ack_irq",  int'(ExtIRQ), 0);
      exp_q.push_back(2);
      write_mask(8'hFF);
      check("t3_unmask_edge", int'(ExtIRQ), 0);
      cyc(1);
      check("t3_unmask_irq",  int'(ExtIRQ), 1);
      check("t3_unmask_id",   int'(irq_id), 2);
      do_eoi();
      check("t3_spur_eoi_irq",  int'(ExtIRQ), 1);
      check("t3_spur_eoi_pend", int'(irq_pending), 8'h04);
      ExtIAck = 1'b1; eoi = 1'b1; cyc(1); ExtIAck = 1'b0; eoi = 1'b0;
      check("t3_ackeoi_irq",  int'(ExtIRQ), 0);
      check("t3_ackeoi_pend", int'(irq_pending), 0);
      irq_src = 8'h10; cyc(1); irq_src = '0; cyc(5);
      check("t3_still_wait", int'(ExtIRQ), 0);
      check("t3_wait_pend",  int'(irq_pending), 8'h10);
      exp_q.push_back(4);
      do_eoi();
      cyc(1);
      check("t3_after_eoi",  int'(ExtIRQ), 1);
      do_ack(); do_eoi();
      cyc(2);

      // Asynchronous reset while requesting, sources held high across release.
      irq_src = 8'h21; exp_q.push_back(0);
      wait_irq(10);
      check("t4_pend", int'(irq_pending), 8'h21);
      #5 reset = 1'b1;
      #1;
      check("t4_async_irq",  int'(ExtIRQ), 0);
      check("t4_async_pend", int'(irq_pending), 0);
      check("t4_async_id",   int'(irq_id), 0);
      cyc(2);
      reset = 1'b0;
      cyc(10);
      check("t4_held_irq",  int'(ExtIRQ), 0);
      check("t4_held_pend", int'(irq_pending), 0);
      irq_src = '0;
      cyc(4);
      check("t4_fall_pend", int'(irq_pending), 0);

      // Random rounds against a pending/mask set model.
      write_mask(8'h00);
      model_pend = '0; in_wait = 1'b0;
      for (int r = 0; r < 40; r++) begin
         rs = 8'($urandom);
         if (rs == 8'h00) rs = 8'(1 << $urandom_range(7, 0));
         irq_src = rs; cyc(1); irq_src = '0; cyc(4);
         model_pend = model_pend | rs;
         check("rnd_pend", int'(irq_pending), int'(model_pend));
         rm = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
         if ((model_pend & rm) == 8'h00) rm = 8'hFF;
         rid = lowest(model_pend & rm);
         exp_q.push_back(rid);
         write_mask(rm);
         if (in_wait) do_eoi();
         wait_irq(8);
         repeat ($urandom_range(4, 0)) begin
            eoi = 1'($urandom_range(1, 0)); cyc(1); eoi = 1'b0;
         end
         ExtIAck = 1'b1; eoi = 1'($urandom_range(1, 0)); cyc(1);
         ExtIAck = 1'b0; eoi = 1'b0;
         model_pend[rid] = 1'b0;
         check("rnd_ack_pend", int'(irq_pending), int'(model_pend));
         check("rnd_ack_irq",  int'(ExtIRQ), 0);
         if ($urandom_range(1, 0) == 1) do_ack();
         in_wait = 1'b1;
      end
      reset = 1'b1; cyc(2); reset = 1'b0; cyc(3);

      // Periodic pulses on source 0, handler acks at once and ends 20 cycles later.
      per_grants = 0;
      fork
         begin
            @(posedge CLOCK_50);
            #5;
            for (int n = 0; n < 8; n++) begin
               exp_q.push_back(0);
               irq_src[0] = 1'b1; #20; irq_src[0] = 1'b0; #490;
            end
         end
         begin
            for (int c = 0; c < 600 && per_grants < 8; c++) begin
               @(negedge CLOCK_50);
               if (ExtIRQ) begin
                  per_grants++;
                  do_ack();
                  cyc(19);
                  do_eoi();
               end
            end
         end
      join
      check("per_grants", per_grants, 8);
      cyc(5);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ext_irq_controller.md
Name: ext_irq_controller

Overview:
- Upstream interrupt source for processor_arm. Collects up to NSRC peripheral interrupt lines, edge-detects and latches them as pending, and applies a per-source mask.
- Arbitrates by fixed priority and drives the processor's single ExtIRQ line with a hold-until-ExtIAck handshake.
- Blocks further requests until the handler signals end-of-interrupt.

Parameters:
- NSRC, 8, number of interrupt source lines (2..32).
- IDW, $clog2(NSRC), width of the granted source id.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  NSRC  raw peripheral interrupt lines; may be asynchronous to CLOCK_50.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NSRC  new mask value; 1 = source enabled.
- ExtIRQ  out  1  interrupt request to processor_arm; registered.
- ExtIAck  in  1  processor acknowledge; sampled on the rising edge.
- eoi  in  1  end-of-interrupt pulse from the handler (ERET path).
- irq_id  out  IDW  id of the granted source; valid while ExtIRQ=1 and in WAIT_EOI.
- irq_pending  out  NSRC  pending register, for debug and dump.
- irq_mask  out  NSRC  current mask register.

Behaviour:
- Reset (asynchronous, immediate) values:
  - ExtIRQ=0, irq_id=0, irq_pending=0, irq_mask=all ones.
  - Synchronizer and edge flops = 0; state = IDLE.
- Reset mid-operation discards any request, grant or pending bits. A source held high through reset deassertion is not a new edge and is not latched.
- Input path, per source:
  - Two-flop synchronizer (s1, s2) plus a previous-value flop p.
  - edge = s2 & ~p.
  - A rising edge on irq_src seen at clock edge k sets pending[i] after edge k+2.
- Pending bits are set by an edge and cleared only on grant-acknowledge. If set and clear hit the same bit in the same cycle, set wins.
- Mask:
  - A mask_we write takes effect on the next edge.
  - Masking does not clear pending bits; they stay latched and are requested when the source is unmasked.
- Candidate = pending & mask. The winner is the lowest set index.
- FSM states IDLE, REQ, WAIT_EOI; ExtIRQ=1 only in REQ.
  - IDLE -> REQ when the candidate set is non-zero; winner latched into irq_id on that edge.
  - REQ -> WAIT_EOI on an edge with ExtIAck=1; pending[irq_id] cleared on the same edge.
  - REQ holds while ExtIAck=0. irq_id is frozen even if the mask or pending bits change meanwhile.
  - WAIT_EOI -> IDLE on an edge with eoi=1.
  - eoi and ack in the same cycle while in REQ: only the ack is honoured.
- Latency:
  - IDLE with a candidate -> ExtIRQ high 1 cycle later.
  - Source edge at k -> ExtIRQ high after edge k+3.
- Back-to-back requests: after eoi, ExtIRQ reasserts no earlier than 1 cycle after returning to IDLE. There is at least one ExtIRQ=0 cycle between grants.
- Out-of-state handshakes:
  - ExtIAck outside REQ is ignored.
  - eoi outside WAIT_EOI is ignored.
- A source edge while that same source is pending is absorbed: one pending bit, no counting.

Decomposition:
- Shared package irq_pkg:
  - state enum irq_state_t {IDLE, REQ, WAIT_EOI}.
  - Default NSRC constant.
  - Priority-encode function (lowest set index, returns IDW bits).
- Sub-module irq_sync_edge: NSRC-wide 2-flop synchronizer plus rising-edge detect. Ports CLOCK_50, reset, d[NSRC], edge[NSRC].
- Top level holds the pending and mask registers, the FSM and the output registers.

Test Plan:
- Single source:
  - Stimulus: irq_src[3] rises at edge 10, ExtIAck tied low.
  - Required: pending=0x08 after edge 12; ExtIRQ=1 and irq_id=3 after edge 13, held indefinitely.
  - Then ExtIAck=1 for one cycle: ExtIRQ=0 and pending=0x00 next cycle; state WAIT_EOI until eoi.
- Priority:
  - Stimulus: irq_src[5] and irq_src[1] rise at the same edge.
  - Required: first grant irq_id=1. After ack+eoi, ExtIRQ drops for at least 1 cycle, then reasserts with irq_id=5.
- Mask:
  - Stimulus: mask=0xFB, then irq_src[2] edge.
  - Required: pending=0x04, ExtIRQ stays 0. Writing mask=0xFF raises ExtIRQ with irq_id=2, 2 cycles after mask_we.
- Periodic stimulus:
  - Stimulus: one-cycle pulse on irq_src[0] every 510 ns; ExtIAck driven high whenever ExtIRQ=1; eoi 20 cycles after ack.
  - Required: every pulse yields exactly one grant; assert ExtIAck==1 whenever ExtIRQ==1 at posedge+1.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while in REQ with pending=0x21.
  - Required: ExtIRQ=0 and pending=0 immediately, before the next clock edge; no request after release while irq_src is held high.
- Spurious handshakes:
  - Stimulus: ExtIAck pulse in IDLE and eoi pulse in REQ.
  - Required: no state change; pending unchanged; ExtIRQ unchanged.
